// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: shared Clause-22 MDIO constants and responder FSM states
package eth_mdio_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA_RD, S_RD_DATA, S_TA_WR, S_WR_DATA, S_WR_CMT
  } mdio_state_t;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_ST = 2'b01;
  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_ID1 = 5'd2;
  localparam logic [4:0] REG_ID2 = 5'd3;
  localparam int MDIO_DATA_W = 16;
endpackage

// File: rtl/eth_mdio_resp_if.sv
// eth_mdio_resp_if: MDIO pad signals plus register-event outputs of the responder
interface eth_mdio_resp_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;
  logic reg_wr_strb;
  logic [4:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic reg_rd_strb;
  logic frame_err;
  modport master (output mdc, mdio_i, input mdio_o, mdio_oe, reg_wr_strb, reg_wr_addr, reg_wr_data, reg_rd_strb, frame_err);
  modport slave (input mdc, mdio_i, output mdio_o, mdio_oe, reg_wr_strb, reg_wr_addr, reg_wr_data, reg_rd_strb, frame_err);
endinterface

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: 2-FF synchronizers for MDC/MDIO with MDC rise detect, equal delay on both paths
module mdio_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdio_s,
  output logic rise
);
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mdc_q <= '0;
      mdio_q <= '1;
    end else begin
      mdc_q <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio_i};
    end
  assign mdio_s = mdio_q[1];
  assign rise = mdc_q[1] & ~mdc_q[2];
endmodule

// File: rtl/eth_mdio_resp.sv
// eth_mdio_resp: Clause-22 MDIO PHY-side responder serving a 32x16 register file
module eth_mdio_resp
  import eth_mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter bit BCAST_EN = 1'b1,
  parameter int PRE_LEN = 32,
  parameter logic [15:0] PHY_ID1 = 16'h0007,
  parameter logic [15:0] PHY_ID2 = 16'hC0F1
) (
  input logic clk,
  input logic rst_n,
  eth_mdio_resp_if.slave m
);
  localparam int CW = $clog2(PRE_LEN + 1);
  logic mdio_s, rise;
  mdio_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] bcnt;
  logic rd, foreign;
  logic [3:0] pa;
  logic [4:0] ra;
  logic [MDIO_DATA_W-1:0] sh;
  logic [15:0] regs [32];
  logic [4:0] pa_full;
  function automatic logic [15:0] rst_val(input int i);
    return i == int'(REG_ID1) ? PHY_ID1 : i == int'(REG_ID2) ? PHY_ID2 : '0;
  endfunction
  mdio_edge_sync u_sync (.clk(clk), .rst_n(rst_n), .mdc(m.mdc), .mdio_i(m.mdio_i), .mdio_s(mdio_s), .rise(rise));
  assign pa_full = {pa, mdio_s};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      bcnt <= '0;
      rd <= 1'b0;
      foreign <= 1'b0;
      pa <= '0;
      ra <= '0;
      sh <= '0;
      m.mdio_o <= 1'b1;
      m.mdio_oe <= 1'b0;
      m.reg_wr_strb <= 1'b0;
      m.reg_wr_addr <= '0;
      m.reg_wr_data <= '0;
      m.reg_rd_strb <= 1'b0;
      m.frame_err <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= rst_val(i);
    end else begin
      m.reg_wr_strb <= 1'b0;
      m.reg_rd_strb <= 1'b0;
      m.frame_err <= 1'b0;
      if (state == S_WR_CMT) begin
        state <= S_IDLE;
        if (ra != REG_ID1 && ra != REG_ID2) begin
          m.reg_wr_strb <= 1'b1;
          m.reg_wr_addr <= ra;
          m.reg_wr_data <= sh;
          // soft reset wins over the write itself, so BMCR reads back its reset value
          if (ra == REG_BMCR && sh[15]) for (int i = 0; i < 32; i++) regs[i] <= rst_val(i);
          else regs[ra] <= sh;
        end
      end else if (rise) begin
        case (state)
          S_IDLE: begin
            if (mdio_s) cnt <= (cnt == CW'(PRE_LEN)) ? cnt : cnt + 1'b1;
            else begin
              cnt <= '0;
              if (cnt == CW'(PRE_LEN)) state <= S_ST;
            end
          end
          S_ST: begin
            bcnt <= '0;
            state <= (mdio_s == MDIO_ST[0]) ? S_OP : S_IDLE;
            m.frame_err <= mdio_s != MDIO_ST[0];
          end
          S_OP: begin
            rd <= mdio_s;
            bcnt <= bcnt + 1'b1;
            if (bcnt == 4'd1) begin
              bcnt <= '0;
              rd <= {rd, mdio_s} == MDIO_OP_RD;
              state <= ({rd, mdio_s} == MDIO_OP_RD || {rd, mdio_s} == MDIO_OP_WR) ? S_PHYAD : S_IDLE;
              m.frame_err <= !({rd, mdio_s} == MDIO_OP_RD || {rd, mdio_s} == MDIO_OP_WR);
            end
          end
          S_PHYAD: begin
            pa <= pa_full[3:0];
            bcnt <= bcnt + 1'b1;
            if (bcnt == 4'd4) begin
              bcnt <= '0;
              foreign <= !(pa_full == PHY_ADDR || (BCAST_EN && pa_full == 5'd0));
              state <= S_REGAD;
            end
          end
          S_REGAD: begin
            ra <= {ra[3:0], mdio_s};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 4'd4) begin
              bcnt <= '0;
              state <= foreign ? S_IDLE : rd ? S_TA_RD : S_TA_WR;
            end
          end
          S_TA_RD: begin
            if (bcnt == 4'd0) begin
              m.reg_rd_strb <= 1'b1;
              sh <= regs[ra];
              m.mdio_oe <= 1'b1;
              m.mdio_o <= 1'b0;
              bcnt <= 4'd1;
            end else begin
              m.mdio_o <= sh[15];
              sh <= {sh[14:0], 1'b0};
              bcnt <= 4'd15;
              state <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            if (bcnt == 4'd0) begin
              m.mdio_oe <= 1'b0;
              m.mdio_o <= 1'b1;
              state <= S_IDLE;
            end else begin
              m.mdio_o <= sh[15];
              sh <= {sh[14:0], 1'b0};
              bcnt <= bcnt - 1'b1;
            end
          end
          S_TA_WR: begin
            bcnt <= bcnt + 1'b1;
            if (mdio_s != (bcnt == 4'd0)) begin
              m.frame_err <= 1'b1;
              state <= S_IDLE;
            end else if (bcnt == 4'd1) begin
              bcnt <= '0;
              state <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            sh <= {sh[14:0], mdio_s};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 4'd15) state <= S_WR_CMT;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_eth_mdio_resp.sv
// tb_eth_mdio_resp: station-manager model driving MDIO frames; strobes checked against an expected-event queue
module tb_eth_mdio_resp;
  typedef struct {
    int kind;
    logic [4:0] a;
    logic [15:0] d;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_drv = 1'b1;
  int total = 0;
  int bad = 0;
  logic oe_acc = 1'b0;
  ev_t exp_q[$];
  eth_mdio_resp_if bus();
  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : m_drv;
  eth_mdio_resp #(.PHY_ADDR(5'd1), .BCAST_EN(1'b1), .PRE_LEN(32), .PHY_ID1(16'h0007), .PHY_ID2(16'hC0F1)) dut (
    .clk(clk), .rst_n(rst_n), .m(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic ex(input int k, input logic [4:0] a, input logic [15:0] d);
    exp_q.push_back('{k, a, d});
  endtask
  task automatic bitx(input logic b, output logic s, output logic so);
    m_drv = b;
    bus.mdc = 1'b0;
    #100;
    s = bus.mdio_i;
    so = bus.mdio_oe;
    oe_acc |= bus.mdio_oe;
    bus.mdc = 1'b1;
    #100;
    oe_acc |= bus.mdio_oe;
  endtask
  task automatic send(input logic [31:0] v, input int n);
    logic s, so;
    for (int i = n - 1; i >= 0; i--) bitx(v[i], s, so);
  endtask
  task automatic pre(input int n);
    logic s, so;
    for (int i = 0; i < n; i++) bitx(1'b1, s, so);
  endtask
  task automatic wr(input int np, input logic [4:0] pa, input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
    pre(np);
    send({2'b01, 2'b01, pa, ra, ta, d}, 32);
  endtask
  task automatic rd(input int np, input logic [4:0] pa, input logic [4:0] ra, input bit ans, input logic [15:0] exv, input int abort);
    logic s, so;
    logic [15:0] v;
    oe_acc = 1'b0;
    pre(np);
    send({18'd0, 2'b01, 2'b10, pa, ra}, 14);
    bitx(1'b1, s, so);
    if (ans) chk("ta1_oe", {31'd0, so}, 32'd0);
    bitx(1'b1, s, so);
    if (ans) chk("ta2_drive", {30'd0, so, s}, 32'd2);
    for (int i = 15; i >= 0; i--) begin
      if (abort == i) begin
        m_drv = 1'b1;
        bus.mdc = 1'b0;
        #50;
        chk("abort_pre_oe", {31'd0, bus.mdio_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_oe", {31'd0, bus.mdio_oe}, 32'd0);
        chk("abort_o", {31'd0, bus.mdio_o}, 32'd1);
        #200;
        rst_n = 1'b1;
        #100;
        return;
      end
      bitx(1'b1, s, so);
      v[i] = s;
    end
    if (ans) begin
      chk("rdata", {16'd0, v}, {16'd0, exv});
      bus.mdc = 1'b0;
      #100;
      chk("release_oe", {31'd0, bus.mdio_oe}, 32'd0);
    end else chk("foreign_oe", {31'd0, oe_acc}, 32'd0);
  endtask
  always @(negedge clk) begin
    int k;
    ev_t e;
    if (rst_n && (bus.reg_wr_strb || bus.reg_rd_strb || bus.frame_err)) begin
      k = bus.reg_wr_strb ? 1 : bus.reg_rd_strb ? 2 : 3;
      if (exp_q.size() == 0) chk("spurious_evt", k, 0);
      else begin
        e = exp_q.pop_front();
        chk("evt_kind", k, e.kind);
        if (k == 1) begin
          chk("wr_addr", {27'd0, bus.reg_wr_addr}, {27'd0, e.a});
          chk("wr_data", {16'd0, bus.reg_wr_data}, {16'd0, e.d});
        end
      end
    end
  end
  initial begin
    bus.mdc = 1'b0;
    #23;
    chk("rst_o", {31'd0, bus.mdio_o}, 32'd1);
    chk("rst_oe", {31'd0, bus.mdio_oe}, 32'd0);
    chk("rst_strb", {29'd0, bus.reg_wr_strb, bus.reg_rd_strb, bus.frame_err}, 32'd0);
    chk("rst_addr", {27'd0, bus.reg_wr_addr}, 32'd0);
    chk("rst_data", {16'd0, bus.reg_wr_data}, 32'd0);
    #17 rst_n = 1'b1;
    #50;
    ex(1, 5'd4, 16'hA5C3); wr(32, 5'd1, 5'd4, 2'b10, 16'hA5C3);
    ex(2, 0, 0); rd(32, 5'd1, 5'd4, 1, 16'hA5C3, -1);
    ex(2, 0, 0); rd(32, 5'd1, 5'd2, 1, 16'h0007, -1);
    ex(2, 0, 0); rd(32, 5'd1, 5'd3, 1, 16'hC0F1, -1);
    wr(32, 5'd1, 5'd2, 2'b10, 16'h1234);
    ex(2, 0, 0); rd(32, 5'd1, 5'd2, 1, 16'h0007, -1);
    rd(32, 5'd5, 5'd4, 0, 16'h0, -1);
    ex(2, 0, 0); rd(32, 5'd0, 5'd4, 1, 16'hA5C3, -1);
    rd(31, 5'd1, 5'd4, 0, 16'h0, -1);
    ex(3, 0, 0); pre(32); send(32'b00, 2);
    ex(3, 0, 0); pre(32); send(32'b0111, 4);
    ex(2, 0, 0); rd(32, 5'd1, 5'd4, 1, 16'hA5C3, -1);
    ex(3, 0, 0); wr(32, 5'd1, 5'd4, 2'b11, 16'h5555);
    ex(2, 0, 0); rd(32, 5'd1, 5'd4, 1, 16'hA5C3, -1);
    ex(1, 5'd4, 16'hFFFF); wr(32, 5'd1, 5'd4, 2'b10, 16'hFFFF);
    ex(1, 5'd0, 16'h8000); wr(32, 5'd1, 5'd0, 2'b10, 16'h8000);
    ex(2, 0, 0); rd(32, 5'd1, 5'd4, 1, 16'h0000, -1);
    ex(2, 0, 0); rd(32, 5'd1, 5'd0, 1, 16'h0000, -1);
    ex(2, 0, 0); rd(32, 5'd1, 5'd2, 1, 16'h0007, -1);
    ex(2, 0, 0); rd(32, 5'd1, 5'd3, 1, 16'hC0F1, 7);
    ex(2, 0, 0); rd(32, 5'd1, 5'd3, 1, 16'hC0F1, -1);
    #500;
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
